// File: rtl/hv_inst_loop_sequencer_pkg.sv
// Shared types and defaults for the instruction-loop sequencer: loop-mode encoding,
// FSM states, per-loop configuration record and the CSR loop-field layout.
package hv_inst_loop_sequencer_pkg;

   localparam int NUM_LOOPS   = 3;
   localparam int ADDR_WIDTH  = 8;
   localparam int COUNT_WIDTH = 8;

   // Bit offsets of loop 0/1/2 inside the packed CSR jump/end/count fields.
   localparam int LOOP0_OFFSET = 0;
   localparam int LOOP1_OFFSET = 8;
   localparam int LOOP2_OFFSET = 16;

   typedef enum logic [1:0] {
      LOOP_MODE_ONE       = 2'd0,
      LOOP_MODE_TWO       = 2'd1,
      LOOP_MODE_THREE     = 2'd2,
      LOOP_MODE_THREE_ALT = 2'd3
   } loop_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]  jump;
      logic [ADDR_WIDTH-1:0]  end_addr;
      logic [COUNT_WIDTH-1:0] count;
   } loop_cfg_t;

   // Number of active loops; the spare encoding 3 behaves like 2.
   function automatic logic [1:0] active_loops(input logic [1:0] mode);
      return (mode == LOOP_MODE_THREE_ALT) ? 2'd3 : mode + 2'd1;
   endfunction

endpackage

// File: rtl/hv_loop_counter.sv
// Iteration counter for one hardware loop; is_last_o flags the final pass
// (a programmed count of 0 behaves like 1).
module hv_loop_counter
   import hv_inst_loop_sequencer_pkg::*;
#(
   parameter int CountWidth = COUNT_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clr_i,
   input  logic                  inc_i,
   input  logic [CountWidth-1:0] count_i,
   output logic                  is_last_o
);

   logic [CountWidth-1:0] cnt_q, cnt_d;
   logic [CountWidth-1:0] last_val;

   always_comb begin
      last_val = (count_i == '0) ? '0 : count_i - 1'b1;
      cnt_d    = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign is_last_o = (cnt_q == last_val);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hv_inst_loop_sequencer.sv
// Program-counter sequencer: issues one PC per accepted instruction, runs up to
// three nested hardware loops and pulses done when the outermost active loop ends.
module hv_inst_loop_sequencer
   import hv_inst_loop_sequencer_pkg::*;
#(
   parameter int NumLoops   = NUM_LOOPS,
   parameter int AddrWidth  = ADDR_WIDTH,
   parameter int CountWidth = COUNT_WIDTH
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           start_i,
   input  logic                           clr_i,
   input  logic [1:0]                     loop_mode_i,
   input  logic [NumLoops*AddrWidth-1:0]  jump_addr_i,
   input  logic [NumLoops*AddrWidth-1:0]  end_addr_i,
   input  logic [NumLoops*CountWidth-1:0] loop_count_i,
   output logic [AddrWidth-1:0]           pc_o,
   output logic                           inst_valid_o,
   input  logic                           inst_ready_i,
   output logic                           busy_o,
   output logic                           done_o
);

   seq_state_e           state_q, state_d;
   logic [AddrWidth-1:0] pc_q, pc_d;

   loop_cfg_t            cfg [NumLoops];
   logic [1:0]           num_active;
   logic [NumLoops-1:0]  at_end, is_last, jump_req, jump_sel, pre_jump;
   logic [NumLoops-1:0]  cnt_inc, cnt_clr;
   logic [AddrWidth-1:0] jump_target;
   logic                 handshake, any_jump, finish;

   assign num_active = active_loops(loop_mode_i);
   assign handshake  = (state_q == ST_RUN) && inst_ready_i;

   generate
      for (genvar gi = 0; gi < NumLoops; gi++) begin : g_loop
         assign cfg[gi] = {jump_addr_i[gi*AddrWidth +: AddrWidth],
                           end_addr_i[gi*AddrWidth +: AddrWidth],
                           loop_count_i[gi*CountWidth +: CountWidth]};

         assign at_end[gi]   = (num_active > 2'(gi)) && (pc_q == cfg[gi].end_addr);
         assign jump_req[gi] = at_end[gi] && !is_last[gi];

         // Loops below the jumping one that sit on their end have run out and rewind to 0.
         assign cnt_inc[gi] = handshake && jump_sel[gi];
         assign cnt_clr[gi] = clr_i || (handshake && (finish || (at_end[gi] && pre_jump[gi])));

         hv_loop_counter #(
            .CountWidth(CountWidth)
         ) u_loop_counter (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .clr_i    (cnt_clr[gi]),
            .inc_i    (cnt_inc[gi]),
            .count_i  (cfg[gi].count),
            .is_last_o(is_last[gi])
         );
      end
   endgenerate

   // Innermost loop wanting to jump wins; pre_jump marks every loop scanned before it.
   always_comb begin
      jump_sel    = '0;
      pre_jump    = '0;
      any_jump    = 1'b0;
      jump_target = '0;
      for (int k = 0; k < NumLoops; k++) begin
         if (!any_jump) begin
            if (jump_req[k]) begin
               any_jump    = 1'b1;
               jump_sel[k] = 1'b1;
               jump_target = cfg[k].jump;
            end else begin
               pre_jump[k] = 1'b1;
            end
         end
      end
   end

   assign finish = !any_jump && at_end[num_active - 2'd1];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_RUN;
               pc_d    = '0;
            end
         end
         ST_RUN: begin
            if (inst_ready_i) begin
               if (any_jump) begin
                  pc_d = jump_target;
               end else if (finish) begin
                  state_d = ST_DONE;
                  pc_d    = '0;
               end else begin
                  pc_d = pc_q + 1'b1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (clr_i) begin
         state_d = ST_IDLE;
         pc_d    = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   assign pc_o         = pc_q;
   assign inst_valid_o = (state_q == ST_RUN);
   assign busy_o       = (state_q == ST_RUN);
   assign done_o       = (state_q == ST_DONE);

endmodule

// File: tb/tb_hv_inst_loop_sequencer.sv
// Self-checking bench for hv_inst_loop_sequencer: directed program table,
// clear/reset corner sequences and randomized nested-loop programs vs. a reference model.
module tb_hv_inst_loop_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start, clr, ready;
   logic [1:0]  loop_mode;
   logic [23:0] jump_addr, end_addr, loop_count;
   logic [7:0]  pc;
   logic        valid, busy, done;

   int errors = 0;
   int checks = 0;
   int exp_pc[$];

   typedef struct {
      string       name;
      logic [1:0]  mode;
      logic [23:0] jmp;
      logic [23:0] ed;
      logic [23:0] cn;
      int          rmode;
      string       seq;
   } vec_t;

   vec_t tbl[8];

   always #5 clk = ~clk;

   hv_inst_loop_sequencer dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .clr_i       (clr),
      .loop_mode_i (loop_mode),
      .jump_addr_i (jump_addr),
      .end_addr_i  (end_addr),
      .loop_count_i(loop_count),
      .pc_o        (pc),
      .inst_valid_o(valid),
      .inst_ready_i(ready),
      .busy_o      (busy),
      .done_o      (done)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic set_cfg(input logic [1:0] m, input logic [23:0] j, input logic [23:0] e,
                          input logic [23:0] c);
      loop_mode  = m;
      jump_addr  = j;
      end_addr   = e;
      loop_count = c;
   endtask

   task automatic load_seq(input string s);
      exp_pc.delete();
      for (int i = 0; i < s.len(); i++) exp_pc.push_back(int'(s[i]) - 48);
   endtask

   // Reference: walk the program with the loop rules applied to plain integers.
   function automatic void build_model();
      int a, p, jk;
      int c[3], e[3], j[3], eff[3];
      for (int k = 0; k < 3; k++) begin
         e[k]   = int'(end_addr[k*8 +: 8]);
         j[k]   = int'(jump_addr[k*8 +: 8]);
         eff[k] = (loop_count[k*8 +: 8] == 8'd0) ? 1 : int'(loop_count[k*8 +: 8]);
         c[k]   = 0;
      end
      a = (loop_mode > 2'd2) ? 3 : int'(loop_mode) + 1;
      exp_pc.delete();
      p = 0;
      for (int s = 0; s < 5000; s++) begin
         exp_pc.push_back(p);
         jk = -1;
         for (int k = 0; k < a; k++) begin
            if (p == e[k] && c[k] != eff[k] - 1) begin
               jk = k;
               break;
            end
         end
         if (jk >= 0) begin
            for (int q = 0; q < jk; q++) if (p == e[q]) c[q] = 0;
            c[jk]++;
            p = j[jk];
         end else if (p == e[a-1]) begin
            return;
         end else begin
            for (int k = 0; k < a; k++) if (p == e[k]) c[k] = 0;
            p = (p + 1) % 256;
         end
      end
   endfunction

   // Called at a negedge with the DUT idle; checks every issued PC and the done pulse.
   task automatic run_prog(input string tag, input int rmode);
      int   idx, cyc;
      logic r;
      idx   = 0;
      cyc   = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (idx < exp_pc.size() && cyc < 4000) begin
         case (rmode)
            0:       r = 1'b1;
            1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: r = 1'($urandom_range(0, 1));
         endcase
         ready = r;
         if (rmode == 2) start = 1'($urandom_range(0, 1));
         chk({tag, " valid"}, valid, 1);
         chk({tag, " busy"}, busy, 1);
         chk({tag, " done_early"}, done, 0);
         if (r) begin
            chk($sformatf("%s pc[%0d]", tag, idx), pc, exp_pc[idx]);
            idx++;
         end
         @(negedge clk);
         cyc++;
      end
      if (idx < exp_pc.size()) chk({tag, " timeout"}, idx, exp_pc.size());
      start = 1'b0;
      ready = 1'b0;
      chk({tag, " done_pulse"}, done, 1);
      chk({tag, " busy_in_done"}, busy, 0);
      chk({tag, " valid_in_done"}, valid, 0);
      @(negedge clk);
      chk({tag, " done_single"}, done, 0);
      chk({tag, " valid_idle"}, valid, 0);
      chk({tag, " busy_idle"}, busy, 0);
      $display("program %s: %0d PCs over %0d cycles", tag, idx, cyc);
   endtask

   initial begin
      start = 1'b0;
      clr   = 1'b0;
      ready = 1'b0;
      set_cfg(2'd0, 24'h0, 24'h0, 24'h0);

      #2 rst_n = 1'b0;
      #1;
      chk("reset pc", pc, 0);
      chk("reset valid", valid, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle no start valid", valid, 0);
      chk("idle no start busy", busy, 0);

      tbl[0] = '{"mode0_loop",  2'd0, 24'h000001, 24'h000003, 24'h000003, 0, "0123123123"};
      tbl[1] = '{"nested",      2'd1, 24'h000002, 24'h000403, 24'h000202, 0, "01232340123234"};
      tbl[2] = '{"shared_end",  2'd1, 24'h000001, 24'h000202, 24'h000202, 0, "0121201212"};
      tbl[3] = '{"count0",      2'd0, 24'h000000, 24'h000002, 24'h000000, 0, "012"};
      tbl[4] = '{"count1",      2'd0, 24'h000000, 24'h000002, 24'h000001, 0, "012"};
      tbl[5] = '{"ready_1001",  2'd1, 24'h000002, 24'h000403, 24'h000202, 1, "01232340123234"};
      tbl[6] = '{"mode3_as_2",  2'd3, 24'h000001, 24'h040302, 24'h020102, 0, "01212340121234"};
      tbl[7] = '{"single_inst", 2'd0, 24'h000000, 24'h000000, 24'h000000, 0, "0"};

      for (int n = 0; n < 8; n++) begin
         set_cfg(tbl[n].mode, tbl[n].jmp, tbl[n].ed, tbl[n].cn);
         load_seq(tbl[n].seq);
         run_prog(tbl[n].name, tbl[n].rmode);
      end

      // PC wraps from 255 to 0 without complaint.
      set_cfg(2'd0, 24'h0000FE, 24'h000001, 24'h000002);
      exp_pc = '{0, 1, 254, 255, 0, 1};
      run_prog("wrap", 0);

      // Clear together with start mid-run: back to idle, no done, counters rewound.
      set_cfg(tbl[1].mode, tbl[1].jmp, tbl[1].ed, tbl[1].cn);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("pre_clr pc", pc, 2);
      clr   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      clr   = 1'b0;
      start = 1'b0;
      ready = 1'b0;
      chk("clr pc", pc, 0);
      chk("clr valid", valid, 0);
      chk("clr busy", busy, 0);
      chk("clr done", done, 0);
      @(negedge clk);
      chk("clr stays idle", valid, 0);
      chk("clr no done", done, 0);
      load_seq(tbl[1].seq);
      run_prog("after_clr", 0);

      // Asynchronous reset mid-run.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ready = 1'b1;
      repeat (5) @(negedge clk);
      chk("pre_rst pc", pc, 3);
      rst_n = 1'b0;
      #1;
      chk("rst pc", pc, 0);
      chk("rst valid", valid, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_prog("after_rst", 0);

      // Randomized properly nested programs; loops beyond the active set get junk config.
      for (int t = 0; t < 25; t++) begin
         int m, a;
         int e[3], j[3], c[3];
         m    = $urandom_range(0, 3);
         a    = (m > 2) ? 3 : m + 1;
         e[0] = $urandom_range(0, 6);
         e[1] = e[0] + $urandom_range(0, 4);
         e[2] = e[1] + $urandom_range(0, 4);
         j[0] = $urandom_range(0, e[0]);
         j[1] = $urandom_range(0, j[0]);
         j[2] = $urandom_range(0, j[1]);
         for (int k = 0; k < 3; k++) c[k] = $urandom_range(0, 3);
         for (int k = a; k < 3; k++) begin
            e[k] = $urandom_range(0, 255);
            j[k] = $urandom_range(0, 255);
            c[k] = $urandom_range(0, 255);
         end
         set_cfg(2'(m), {8'(j[2]), 8'(j[1]), 8'(j[0])}, {8'(e[2]), 8'(e[1]), 8'(e[0])},
                 {8'(c[2]), 8'(c[1]), 8'(c[0])});
         build_model();
         run_prog($sformatf("rand%0d", t), 2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hv_inst_loop_sequencer.md
Name: hv_inst_loop_sequencer

Overview:
- Program-counter sequencer for the instruction memory, driven by the CSR instruction-loop fields: loop mode, jump addresses, end addresses and loop counts.
- Issues one PC per accepted instruction and executes up to three nested hardware loops.
- Raises a done pulse when the outermost active loop finishes.
- Sits between the CSR set and the instruction memory/decoder, and reports busy back to the CSR busy bit.

Parameters:
- NumLoops, 3, number of hardware loops (loop 0 innermost).
- AddrWidth, 8, instruction address width; matches the 8-bit CSR jump/end fields.
- CountWidth, 8, loop-iteration count width.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  start pulse (CSR start-core bit)
- clr_i  input  1  synchronous clear (CSR instruction-clear bit)
- loop_mode_i  input  2  number of active loops minus 1 (0..2); value 3 is treated as 2
- jump_addr_i  input  NumLoops*AddrWidth  per-loop jump-back address
- end_addr_i  input  NumLoops*AddrWidth  per-loop last-instruction address
- loop_count_i  input  NumLoops*CountWidth  per-loop iteration count
- pc_o  output  AddrWidth  current instruction address
- inst_valid_o  output  1  pc_o is valid for fetch/execute
- inst_ready_i  input  1  downstream accepts pc_o (handshake)
- busy_o  output  1  sequencer running
- done_o  output  1  single-cycle pulse on program completion

Behaviour:
- Reset values: pc_o=0, inst_valid_o=0, busy_o=0, done_o=0, all iteration counters=0, state=IDLE.
- States and transitions:
  - IDLE: start_i moves to RUN next cycle with pc=0.
  - RUN: inst_valid_o=1 and busy_o=1.
  - DONE: lasts 1 cycle with done_o=1, busy_o=0, then returns to IDLE.
- clr_i in any state: next cycle is IDLE, pc=0, counters=0, no done pulse. clr_i wins over a simultaneous start_i.
- start_i while in RUN or DONE is ignored.
- Config inputs are sampled live. Software must hold them stable while busy_o=1.
- Active loops A = min(loop_mode_i,2)+1. Loops k>=A are ignored.
- PC advances only on handshake (inst_valid_o && inst_ready_i). Without a handshake, pc and counters hold.
- Effective count: eff[k] = (loop_count_i[k]==0) ? 1 : loop_count_i[k]. Count 0 behaves as 1.
- On handshake, scan k=0..A-1 in order:
  - Jump: the first k with pc==end_addr[k] and cnt[k] != eff[k]-1 sets pc <= jump_addr[k] and cnt[k]++.
  - Every j<k that also has pc==end_addr[j] sets cnt[j] <= 0, because the inner loop has finished.
- No jump, and pc==end_addr[A-1]: program finished. All counters are cleared, next state is DONE, inst_valid_o falls the next cycle.
- No jump otherwise: pc <= pc+1, wrapping modulo 2^AddrWidth. There is no error on wrap.
- Latency: 1 cycle from start_i to the first valid PC (0). Each handshake yields the next PC on the following cycle. done_o asserts the cycle after the final handshake.
- Reset mid-operation: asynchronous return to reset values.

Decomposition:
- Shared package: loop-mode encodings and a typedef for the per-loop config struct {jump, end, count}.
- The package also holds the NumLoops/width defaults, aligned with the CSR loop-field bit offsets (0/8/16).
- One natural sub-module, hv_loop_counter: per-loop counter with inc/clear and an is-last flag, instantiated NumLoops times.
- Jump-priority selection and the FSM stay in the top module.

Test Plan:
- Mode 0, end[0]=3, jump[0]=1, count[0]=3, ready always 1 -> PC sequence 0,1,2,3,1,2,3,1,2,3, then done_o pulses once and busy_o falls.
- Mode 1, loop0 jump=2 end=3 count=2; loop1 jump=0 end=4 count=2 -> PC sequence 0,1,2,3,2,3,4,0,1,2,3,2,3,4, then done.
- Shared end: mode 1, loop0 jump=1 end=2 count=2; loop1 jump=0 end=2 count=2 -> PC sequence 0,1,2,1,2,0,1,2,1,2, then done. Loop0 counter reads 0 at each outer jump.
- Count 0 on loop0 (end=2) -> PC sequence 0,1,2, then done; identical to count=1.
- inst_ready_i toggled 1,0,0,1 -> pc_o and counters hold during the 0 cycles; the sequence is unchanged apart from timing.
- clr_i asserted mid-RUN together with start_i -> next cycle IDLE, pc_o=0, inst_valid_o=0, no done_o. rst_ni pulsed low mid-run returns all outputs to 0 immediately.
